// File: rtl/hex_scan_n.sv
// hex_scan_n: N-digit time-multiplexed hex display scanner (AN = digit index, D = nibble).
// Latency: inputs are snapshotted on the frame wrap, so a change shows within DIGITS*SCAN_DIV cycles.
// Backpressure: none; free-running scan, outputs are decoded from registers only.
module hex_scan_n #(
    parameter int  DIGITS   = 8,
    parameter int  SCAN_DIV = 250000,
    localparam int AW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] data,
    input  logic [DIGITS-1:0]   en_mask,
    input  logic                lz_blank,
    output logic [AW-1:0]       AN,
    output logic [3:0]          D,
    output logic                blank,
    output logic                frame_start
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0]       cnt;
    logic [AW-1:0]       idx;
    logic [4*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   mask_q;
    logic                lz_q;
    logic                tick;
    logic                wrap;

    assign tick = (cnt == CW'(SCAN_DIV - 1));
    assign wrap = tick && (idx == AW'(DIGITS - 1));

    // The snapshot and the idx return to 0 share the wrap edge, so digit 0
    // of the new frame is always shown with the freshly captured value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            lz_q        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + 1'b1;
            frame_start <= wrap;
            if (wrap) begin
                idx    <= '0;
                data_q <= data;
                mask_q <= en_mask;
                lz_q   <= lz_blank;
            end else if (tick) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Digit k is a leading zero when it and every digit above it are zero;
    // the mask is deliberately ignored here. Digit 0 is never suppressed.
    logic [DIGITS-1:0] lz_vec;
    assign lz_vec[0] = 1'b0;
    for (genvar k = 1; k < DIGITS; k++) begin : g_lz
        assign lz_vec[k] = lz_q && (data_q[4*DIGITS-1:4*k] == '0);
    end

    logic       sel_mask;
    logic       sel_lz;
    logic [3:0] sel_nib;

    always_comb begin
        sel_mask = 1'b0;
        sel_lz   = 1'b0;
        sel_nib  = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == AW'(k)) begin
                sel_mask = mask_q[k];
                sel_lz   = lz_vec[k];
                sel_nib  = data_q[4*k +: 4];
            end
        end
    end

    assign AN    = idx;
    assign blank = !sel_mask || sel_lz;
    assign D     = blank ? 4'h0 : sel_nib;

endmodule

// File: tb/tb_hex_scan_n.sv
// Directed bench for hex_scan_n: DIGITS=4/SCAN_DIV=3 main instance plus a DIGITS=1/SCAN_DIV=1 edge instance.
module tb_hex_scan_n;

    logic        clk;
    logic        reset;
    logic [15:0] data;
    logic [3:0]  en_mask;
    logic        lz_blank;
    logic [1:0]  AN;
    logic [3:0]  D;
    logic        blank;
    logic        frame_start;

    logic [3:0]  data_e;
    logic [0:0]  mask_e;
    logic        lz_e;
    logic [0:0]  AN_e;
    logic [3:0]  D_e;
    logic        blank_e;
    logic        fs_e;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    hex_scan_n #(.DIGITS(4), .SCAN_DIV(3)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .en_mask     (en_mask),
        .lz_blank    (lz_blank),
        .AN          (AN),
        .D           (D),
        .blank       (blank),
        .frame_start (frame_start)
    );

    hex_scan_n #(.DIGITS(1), .SCAN_DIV(1)) u_e (
        .clk         (clk),
        .reset       (reset),
        .data        (data_e),
        .en_mask     (mask_e),
        .lz_blank    (lz_e),
        .AN          (AN_e),
        .D           (D_e),
        .blank       (blank_e),
        .frame_start (fs_e)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic to_next_frame();
        step();
        while ((cyc % 12) != 0) step();
    endtask

    task automatic test_reset();
        data = 16'h1234; en_mask = 4'hF; lz_blank = 1'b0;
        do_reset();
        checks++;
        if (AN !== 2'd0 || D !== 4'h0 || blank !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: AN=%0d D=%h blank=%b fs=%b, want AN=0 D=0 blank=1 fs=0",
                     AN, D, blank, frame_start);
        end
        for (int c = 1; c < 12; c++) begin
            step();
            checks++;
            if (AN !== 2'(c / 3) || D !== 4'h0 || blank !== 1'b1 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL first_frame_blank c=%0d: AN=%0d D=%h blank=%b fs=%b, want AN=%0d D=0 blank=1 fs=0",
                         c, AN, D, blank, frame_start, c / 3);
            end
        end
        step();
        checks++;
        if (frame_start !== 1'b1 || AN !== 2'd0 || D !== 4'h4 || blank !== 1'b0) begin
            errors++;
            $display("FAIL first_frame_start: AN=%0d D=%h blank=%b fs=%b, want AN=0 D=4 blank=0 fs=1",
                     AN, D, blank, frame_start);
        end
    endtask

    task automatic test_scan();
        logic [3:0] ed [4];
        int k;
        ed = '{4'h4, 4'h3, 4'h2, 4'h1};
        for (int i = 0; i < 24; i++) begin
            if (i > 0) step();
            k = (i % 12) / 3;
            checks++;
            if (AN !== 2'(k) || D !== ed[k] || blank !== 1'b0 || frame_start !== ((i % 12) == 0)) begin
                errors++;
                $display("FAIL scan_1234 i=%0d: AN=%0d D=%h blank=%b fs=%b, want AN=%0d D=%h blank=0 fs=%b",
                         i, AN, D, blank, frame_start, k, ed[k], (i % 12) == 0);
            end
        end
    endtask

    task automatic test_midframe();
        logic [3:0] eo [4];
        logic [3:0] en [4];
        int k;
        eo = '{4'h4, 4'h3, 4'h2, 4'h1};
        en = '{4'hD, 4'hC, 4'hB, 4'hA};
        repeat (4) step();
        data = 16'hABCD;
        for (int i = 3; i < 12; i++) begin
            if (i > 3) step();
            k = i / 3;
            checks++;
            if (AN !== 2'(k) || D !== eo[k] || blank !== 1'b0 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL midframe_old i=%0d: AN=%0d D=%h blank=%b fs=%b, want AN=%0d D=%h blank=0 fs=0",
                         i, AN, D, blank, frame_start, k, eo[k]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            step();
            k = i / 3;
            checks++;
            if (AN !== 2'(k) || D !== en[k] || blank !== 1'b0 || frame_start !== (i == 0)) begin
                errors++;
                $display("FAIL midframe_new i=%0d: AN=%0d D=%h blank=%b fs=%b, want AN=%0d D=%h blank=0 fs=%b",
                         i, AN, D, blank, frame_start, k, en[k], i == 0);
            end
        end
    endtask

    task automatic test_lz();
        logic [3:0] ed [2][4];
        logic       eb [2][4];
        logic [15:0] vals [2];
        int k;
        vals = '{16'h0050, 16'h0000};
        ed = '{'{4'h0, 4'h5, 4'h0, 4'h0}, '{4'h0, 4'h0, 4'h0, 4'h0}};
        eb = '{'{1'b0, 1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1, 1'b1}};
        lz_blank = 1'b1;
        for (int f = 0; f < 2; f++) begin
            data = vals[f];
            to_next_frame();
            for (int i = 0; i < 12; i++) begin
                if (i > 0) step();
                k = i / 3;
                checks++;
                if (AN !== 2'(k) || D !== ed[f][k] || blank !== eb[f][k]) begin
                    errors++;
                    $display("FAIL lz_%h i=%0d: AN=%0d D=%h blank=%b, want AN=%0d D=%h blank=%b",
                             vals[f], i, AN, D, blank, k, ed[f][k], eb[f][k]);
                end
            end
        end
    endtask

    task automatic test_mask();
        logic [3:0]  ed [2][4];
        logic        eb [2][4];
        logic [15:0] vals [2];
        logic [3:0]  masks [2];
        int k;
        vals  = '{16'h8888, 16'h8000};
        masks = '{4'b0101, 4'b0111};
        ed = '{'{4'h8, 4'h0, 4'h8, 4'h0}, '{4'h0, 4'h0, 4'h0, 4'h0}};
        eb = '{'{1'b0, 1'b1, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0, 1'b1}};
        lz_blank = 1'b1;
        for (int f = 0; f < 2; f++) begin
            data = vals[f];
            en_mask = masks[f];
            to_next_frame();
            for (int i = 0; i < 12; i++) begin
                if (i > 0) step();
                k = i / 3;
                checks++;
                if (AN !== 2'(k) || D !== ed[f][k] || blank !== eb[f][k]) begin
                    errors++;
                    $display("FAIL mask_%h_%b i=%0d: AN=%0d D=%h blank=%b, want AN=%0d D=%h blank=%b",
                             vals[f], masks[f], i, AN, D, blank, k, ed[f][k], eb[f][k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        data = 16'h1234; en_mask = 4'hF; lz_blank = 1'b0;
        n = 0;
        while (AN !== 2'd2 && n < 12) begin
            step();
            n++;
        end
        checks++;
        if (AN !== 2'd2) begin
            errors++;
            $display("FAIL reset_mid_find_an2: AN=%0d after %0d cycles, want 2", AN, n);
        end
        do_reset();
        checks++;
        if (AN !== 2'd0 || D !== 4'h0 || blank !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state: AN=%0d D=%h blank=%b fs=%b, want AN=0 D=0 blank=1 fs=0",
                     AN, D, blank, frame_start);
        end
        for (int c = 1; c < 12; c++) begin
            step();
            checks++;
            if (frame_start !== 1'b0 || blank !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_wait c=%0d: blank=%b fs=%b, want blank=1 fs=0",
                         c, blank, frame_start);
            end
        end
        step();
        checks++;
        if (frame_start !== 1'b1 || AN !== 2'd0 || D !== 4'h4 || blank !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_restart: AN=%0d D=%h blank=%b fs=%b, want AN=0 D=4 blank=0 fs=1",
                     AN, D, blank, frame_start);
        end
    endtask

    task automatic test_edge();
        logic [3:0] vd [5];
        logic       vm [5];
        logic [3:0] ed [5];
        logic       eb [5];
        vd = '{4'h5, 4'hA, 4'h0, 4'hF, 4'h7};
        vm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ed = '{4'h5, 4'hA, 4'h0, 4'hF, 4'h0};
        eb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        data_e = 4'h3; mask_e = 1'b1; lz_e = 1'b1;
        do_reset();
        checks++;
        if (AN_e !== 1'b0 || D_e !== 4'h0 || blank_e !== 1'b1 || fs_e !== 1'b0) begin
            errors++;
            $display("FAIL edge_reset: AN=%0d D=%h blank=%b fs=%b, want AN=0 D=0 blank=1 fs=0",
                     AN_e, D_e, blank_e, fs_e);
        end
        for (int i = 0; i < 5; i++) begin
            data_e = vd[i];
            mask_e = vm[i];
            step();
            checks++;
            if (AN_e !== 1'b0 || D_e !== ed[i] || blank_e !== eb[i] || fs_e !== 1'b1) begin
                errors++;
                $display("FAIL edge_follow i=%0d: AN=%0d D=%h blank=%b fs=%b, want AN=0 D=%h blank=%b fs=1",
                         i, AN_e, D_e, blank_e, fs_e, ed[i], eb[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        data = 16'h0; en_mask = 4'h0; lz_blank = 1'b0;
        data_e = 4'h0; mask_e = 1'b0; lz_e = 1'b0;
        repeat (2) step();
        test_reset();
        test_scan();
        test_midframe();
        test_lz();
        test_mask();
        test_reset_mid();
        test_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
